mem_arbiter: RTL and testbench

Synchronous controller and two-port arbiter for the CPUCR main memory (64 KiB × 8, bidirectional data bus, active-low write strobe `LE`). It lets the CPU (port 0) and the program loader/DMA (port 1) share the memory. It also turns single-cycle-clocked requests into properly sequenced `LE` read and write cycles. Port 0 connects to the CPU bus interface and port 1 to the loader. The memory side connects directly to the memory module's `Direccion`, `Datos` and `LE`, with `Datos` driven through a tri-state buffer controlled by `mem_oe`.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and LE-strobe sequencer for the 64 KiB x 8
// main memory. Port 0 is the CPU, port 1 the loader/DMA. Every output is
// registered; the Datos tri-state buffer is steered by mem_oe.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration. Without it,
// port 0 has fixed priority and no pointer register exists.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_le,
  output logic [DW-1:0] mem_dout,
  output logic          mem_oe,
  input  logic [DW-1:0] mem_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SET,
    S_WR_STB,
    S_WR_HLD,
    S_ACK
  } state_t;

  state_t        state_q;
  logic          gnt_q;
  logic          ack0_q;
  logic          ack1_q;
  logic          busy_q;
  logic          mem_le_q;
  logic          mem_oe_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_dout_q;
  logic [DW-1:0] rdata_q;

  logic          win_d;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
  logic rr_q;

  // Pointer toggles on every grant, whichever port was granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else if (state_q == S_IDLE && (req0 || req1)) begin
      rr_q <= ~rr_q;
    end
  end
`endif

  // Pick the winner among pending requests and mux its transaction fields.
  always_comb begin
    win_d = req1;
    if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
      win_d = rr_q;
`else
      win_d = 1'b0;
`endif
    end
    sel_we    = win_d ? we1    : we0;
    sel_addr  = win_d ? addr1  : addr0;
    sel_wdata = win_d ? wdata1 : wdata0;
  end

  // Transaction sequencer with registered memory-side and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_le_q   <= 1'b1;
      mem_oe_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      rdata_q    <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            gnt_q      <= win_d;
            mem_addr_q <= sel_addr;
            busy_q     <= 1'b1;
            if (sel_we) begin
              mem_dout_q <= sel_wdata;
              mem_oe_q   <= 1'b1;
              state_q    <= S_WR_SET;
            end else begin
              state_q    <= S_RD;
            end
          end
        end
        S_RD: begin
          rdata_q <= mem_din;
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
          state_q <= S_ACK;
        end
        S_WR_SET: begin
          mem_le_q <= 1'b0;
          state_q  <= S_WR_STB;
        end
        S_WR_STB: begin
          mem_le_q <= 1'b1;
          state_q  <= S_WR_HLD;
        end
        S_WR_HLD: begin
          mem_oe_q <= 1'b0;
          ack0_q   <= ~gnt_q;
          ack1_q   <= gnt_q;
          state_q  <= S_ACK;
        end
        S_ACK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          mem_le_q <= 1'b1;
          mem_oe_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign rdata    = rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_le   = mem_le_q;
  assign mem_oe   = mem_oe_q;
  assign mem_dout = mem_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural 64 KiB memory that writes on the falling
// edge of LE, a table of single transactions, and hand-written sequences for
// contention, reset abort and request cancel.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, busy, mem_le, mem_oe;
  logic [7:0]  rdata, mem_dout, mem_din;
  logic [15:0] mem_addr;

  logic [7:0]  mem [0:65535];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs [8];

  mem_arbiter #(.AW(16), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_le(mem_le), .mem_dout(mem_dout),
    .mem_oe(mem_oe), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  assign mem_din = mem_oe ? mem_dout : mem[mem_addr];

  // Memory model: initial contents M[i] = i[7:0] ^ 0xC3, M[0x2000] = 0x5A.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[16'h2000] = 8'h5A;
    forever begin
      @(negedge mem_le);
      if (mem_oe === 1'b1) mem[mem_addr] = mem_dout;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [15:0] addr, input logic [7:0] wdata);
    if (port) begin
      req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
    end
  endtask

  // One complete transaction, checked cycle by cycle from E+1 to the IDLE after ACK.
  task automatic run_txn(input int idx, input vec_t v);
    int unsigned n;
    logic exp_ack, exp_le, exp_oe;
    string tag;
    n = v.we ? 4 : 2;
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    for (int unsigned k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      tag     = $sformatf("v%0d_c%0d", idx, k);
      exp_ack = (k == n);
      exp_le  = !(v.we && k == 2);
      exp_oe  = v.we && k <= 3;
      chk({tag, "_le"},   mem_le, exp_le);
      chk({tag, "_oe"},   mem_oe, exp_oe);
      chk({tag, "_busy"}, busy, k <= n);
      chk({tag, "_ack0"}, ack0, exp_ack && !v.port);
      chk({tag, "_ack1"}, ack1, exp_ack && v.port);
      if (k < n) chk({tag, "_addr"}, mem_addr, v.addr);
      if (v.we && k <= 3) chk({tag, "_dout"}, mem_dout, v.wdata);
      if (!v.we && k == n) chk({tag, "_rdata"}, rdata, v.exp_rdata);
      if (k == n) drive(v.port, 1'b0, v.we, v.addr, v.wdata);
    end
    if (v.we) chk($sformatf("v%0d_memcell", idx), mem[v.addr], v.wdata);
  endtask

  initial begin
    int   nacks;
    logic exp_port;

    vecs[0] = '{1'b0, 1'b0, 16'h2000, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, 16'h1000, 8'h0B, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 16'h1000, 8'h00, 8'h0B};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 8'hFF, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'hFF};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8'hC3};
    vecs[6] = '{1'b0, 1'b1, 16'h0002, 8'h3C, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 16'h0002, 8'h00, 8'h3C};

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_le",    mem_le,   1'b1);
    chk("rst_oe",    mem_oe,   1'b0);
    chk("rst_addr",  mem_addr, 16'h0000);
    chk("rst_dout",  mem_dout, 8'h00);
    chk("rst_rdata", rdata,    8'h00);
    chk("rst_ack0",  ack0,     1'b0);
    chk("rst_ack1",  ack1,     1'b0);
    chk("rst_busy",  busy,     1'b0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

    // Reset abort during WR_SET: no strobe, no ack, byte at 0x3000 untouched.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 16'h3000, 8'h77);
    @(negedge clk);
    chk("abort_in_wrset_oe", mem_oe, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_le",   mem_le, 1'b1);
    chk("abort_oe",   mem_oe, 1'b0);
    chk("abort_busy", busy,   1'b0);
    chk("abort_ack1", ack1,   1'b0);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 16'h3000, 8'h77);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_after%0d_ack1", i), ack1, 1'b0);
      chk($sformatf("abort_after%0d_busy", i), busy, 1'b0);
    end
    chk("abort_memcell", mem[16'h3000], 8'hC3);

    // Contention: both ports read continuously; pointer is at port 0 after reset.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 16'h0001, 8'h00);
    nacks = 0;
    for (int c = 0; c < 30 && nacks < 4; c++) begin
      @(negedge clk);
      chk($sformatf("cont_c%0d_excl", c), ack0 & ack1, 1'b0);
      if (ack0 || ack1) begin
`ifdef MEM_ARB_RR_EN
        exp_port = nacks[0];
`else
        exp_port = 1'b0;
`endif
        chk($sformatf("cont_ack%0d_port", nacks), ack1, exp_port);
        chk($sformatf("cont_ack%0d_rdata", nacks), rdata, exp_port ? 8'hC2 : 8'hC3);
        nacks++;
        if (nacks == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    chk("cont_nacks", nacks, 4);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("cont_idle_busy", busy, 1'b0);

    // Cancel: port 1 raises a write while port 0's read is in flight, drops it before IDLE.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h2000, 8'h00);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 16'h4000, 8'h99);
    @(negedge clk);
    chk("cancel_ack0",  ack0,  1'b1);
    chk("cancel_rdata", rdata, 8'h5A);
    chk("cancel_ack1",  ack1,  1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h2000, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 16'h4000, 8'h99);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("cancel_after%0d_ack1", i), ack1, 1'b0);
      chk($sformatf("cancel_after%0d_busy", i), busy, 1'b0);
    end
    chk("cancel_memcell", mem[16'h4000], 8'hC3);
    chk("boundary_m0",    mem[16'h0000], 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
